// File: rtl/mux_scan_seq_if.sv
// Downstream word handshake between the scan sequencer and its consumer.
interface mux_scan_seq_if;
    logic [3:0] word;
    logic       valid;
    logic       ready;

    modport master (output word, output valid, input ready);
    modport slave  (input word, input valid, output ready);
endinterface

// File: rtl/mux_scan_seq.sv
// Steps a 4:1 mux select through channels 0..3, samples y after a settle
// delay on each channel, and hands the assembled 4-bit word downstream.
module mux_scan_seq #(
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CONT   = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           y,
    output logic           s1,
    output logic           s0,
    output logic           busy,
    output logic           start_drop,
    mux_scan_seq_if.master bus
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned WORD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_e;

    // The capture edge itself counts as the last settle cycle, so the wait
    // state holds SETTLE-1 extra cycles and SETTLE=0 goes straight to capture.
    localparam logic [CNT_W-1:0] RELOAD   = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);
    localparam state_e           FIRST_ST = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                busy_q, busy_d;
    logic                valid_q, valid_d;
    logic                start_drop_q, start_drop_d;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            cnt_q        <= '0;
            word_q       <= '0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            start_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            start_drop_q <= start_drop_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        busy_d       = busy_q;
        valid_d      = valid_q;
        start_drop_d = start && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (start) begin
                    word_d  = '0;
                    cnt_d   = RELOAD;
                    state_d = FIRST_ST;
                    busy_d  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                word_d[sel_q] = y;
                if (sel_q != SEL_W'(3)) begin
                    sel_d   = sel_q + SEL_W'(1);
                    cnt_d   = RELOAD;
                    state_d = FIRST_ST;
                end else begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (valid_q && bus.ready) begin
                    valid_d = 1'b0;
                    sel_d   = '0;
                    if (CONT != 0) begin
                        word_d  = '0;
                        cnt_d   = RELOAD;
                        state_d = FIRST_ST;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign s1         = sel_q[1];
    assign s0         = sel_q[0];
    assign busy       = busy_q;
    assign start_drop = start_drop_q;
    assign bus.word   = word_q;
    assign bus.valid  = valid_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Three sequencer instances (SETTLE=1/CONT=0, SETTLE=0/CONT=0, SETTLE=1/CONT=1)
// driven with random mux contents and checked against cycle-offset arithmetic.
module tb_mux_scan_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start_a, start_b, start_c;
    logic [3:0] in_a, in_b, in_c;
    logic       y_a, y_b, y_c;
    logic       s1_a, s0_a, s1_b, s0_b, s1_c, s0_c;
    logic       busy_a, busy_b, busy_c;
    logic       drop_a, drop_b, drop_c;

    mux_scan_seq_if if_a ();
    mux_scan_seq_if if_b ();
    mux_scan_seq_if if_c ();

    // Mux model: y follows the selected input of each DUT's own mux.
    assign y_a = in_a[{s1_a, s0_a}];
    assign y_b = in_b[{s1_b, s0_b}];
    assign y_c = in_c[{s1_c, s0_c}];

    mux_scan_seq #(.SETTLE(1), .CONT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .y(y_a), .s1(s1_a), .s0(s0_a),
        .busy(busy_a), .start_drop(drop_a), .bus(if_a));
    mux_scan_seq #(.SETTLE(0), .CONT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .y(y_b), .s1(s1_b), .s0(s0_b),
        .busy(busy_b), .start_drop(drop_b), .bus(if_b));
    mux_scan_seq #(.SETTLE(1), .CONT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .y(y_c), .s1(s1_c), .s0(s0_c),
        .busy(busy_c), .start_drop(drop_c), .bus(if_c));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int settle_of(input int d);
        return (d == 1) ? 0 : 1;
    endfunction

    function automatic logic [1:0] get_sel(input int d);
        case (d)
            0:       return {s1_a, s0_a};
            1:       return {s1_b, s0_b};
            default: return {s1_c, s0_c};
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic get_valid(input int d);
        case (d)
            0:       return if_a.valid;
            1:       return if_b.valid;
            default: return if_c.valid;
        endcase
    endfunction

    function automatic logic [3:0] get_word(input int d);
        case (d)
            0:       return if_a.word;
            1:       return if_b.word;
            default: return if_c.word;
        endcase
    endfunction

    function automatic logic get_drop(input int d);
        case (d)
            0:       return drop_a;
            1:       return drop_b;
            default: return drop_c;
        endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic set_in(input int d, input logic [3:0] v);
        case (d)
            0:       in_a = v;
            1:       in_b = v;
            default: in_c = v;
        endcase
    endtask

    task automatic set_ready(input int d, input logic v);
        case (d)
            0:       if_a.ready = v;
            1:       if_b.ready = v;
            default: if_c.ready = v;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One scan, m = edges since the launching edge: select = min(m/(S+1),3),
    // busy until the 4th capture at m = 4(S+1), where valid rises with the word.
    task automatic scan(input int d, input logic [3:0] in_v, input int drop_at, input bit do_start);
        int s    = settle_of(d);
        int last = 4 * (s + 1);
        int e_sel;
        set_in(d, in_v);
        if (do_start) set_start(d, 1'b1);
        tick();
        for (int m = 0; m <= last; m++) begin
            set_start(d, m == drop_at);
            e_sel = (m / (s + 1) > 3) ? 3 : m / (s + 1);
            chk("sel",   8'(get_sel(d)),   8'(e_sel));
            chk("busy",  8'(get_busy(d)),  8'(m < last));
            chk("valid", 8'(get_valid(d)), 8'(m == last));
            chk("drop",  8'(get_drop(d)),  8'(drop_at >= 0 && m == drop_at + 1));
            if (m < last) tick();
        end
        chk("word", 8'(get_word(d)), 8'(in_v));
        set_start(d, 1'b0);
    endtask

    // After a handshake with CONT=0 the block is idle with select 00.
    task automatic expect_idle(input int d);
        tick();
        chk("idle_valid", 8'(get_valid(d)), 8'(0));
        chk("idle_busy",  8'(get_busy(d)),  8'(0));
        chk("idle_sel",   8'(get_sel(d)),   8'(0));
    endtask

    task automatic check_reset_vals(input int d);
        chk("rst_word",  8'(get_word(d)),  8'(0));
        chk("rst_valid", 8'(get_valid(d)), 8'(0));
        chk("rst_busy",  8'(get_busy(d)),  8'(0));
        chk("rst_sel",   8'(get_sel(d)),   8'(0));
        chk("rst_drop",  8'(get_drop(d)),  8'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rv;
        int         da;

        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        in_a = '0; in_b = '0; in_c = '0;
        if_a.ready = 1'b1; if_b.ready = 1'b1; if_c.ready = 1'b1;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) check_reset_vals(d);
        rst_n = 1'b1;
        tick();

        // Basic scans plus random contents and random dropped starts.
        scan(0, 4'b1101, -1, 1'b1);
        expect_idle(0);
        scan(1, 4'b0110, -1, 1'b1);
        expect_idle(1);
        for (int i = 0; i < 6; i++) begin
            for (int d = 0; d < 2; d++) begin
                rv = 4'($urandom_range(0, 15));
                da = int'($urandom_range(0, 4 * (settle_of(d) + 1))) - 1;
                scan(d, rv, da, 1'b1);
                expect_idle(d);
            end
        end

        // Backpressure: word held, start in DONE dropped without a new scan.
        set_ready(0, 1'b0);
        scan(0, 4'b1101, -1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            set_start(0, i == 3);
            tick();
            chk("hold_valid", 8'(get_valid(0)), 8'(1));
            chk("hold_word",  8'(get_word(0)),  8'(4'b1101));
            chk("hold_sel",   8'(get_sel(0)),   8'(3));
            chk("hold_busy",  8'(get_busy(0)),  8'(0));
            chk("hold_drop",  8'(get_drop(0)),  8'(i == 3));
        end
        set_start(0, 1'b0);
        set_ready(0, 1'b1);
        expect_idle(0);

        // Continuous mode: back-to-back words, input switched between scans.
        scan(2, 4'b1101, -1, 1'b1);
        scan(2, 4'b0010, -1, 1'b0);
        rv = 4'($urandom_range(0, 15));
        scan(2, rv, -1, 1'b0);
        set_ready(2, 1'b0);

        // Reset after channel 1 is captured discards the partial word.
        rv = 4'($urandom_range(0, 15));
        set_in(0, rv);
        set_start(0, 1'b1);
        tick();
        set_start(0, 1'b0);
        repeat (4) tick();
        chk("part_sel",  8'(get_sel(0)),  8'(2));
        chk("part_word", 8'(get_word(0)), 8'({2'b00, rv[1:0]}));
        rst_n = 1'b0;
        tick();
        check_reset_vals(0);
        check_reset_vals(2);
        rst_n = 1'b1;
        set_ready(2, 1'b1);
        rv = 4'($urandom_range(0, 15));
        scan(0, rv, -1, 1'b1);
        expect_idle(0);

        // Start coincident with reset: reset wins and the block stays idle.
        rst_n = 1'b0;
        set_start(0, 1'b1);
        tick();
        rst_n = 1'b1;
        set_start(0, 1'b0);
        chk("rs_busy", 8'(get_busy(0)), 8'(0));
        chk("rs_sel",  8'(get_sel(0)),  8'(0));
        tick();
        chk("rs_busy2", 8'(get_busy(0)), 8'(0));
        chk("rs_drop",  8'(get_drop(0)), 8'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
